// File: rtl/limb_pkg.sv
// -----------------------------------------------------------------------------
// limb_pkg
// Shared definitions for the execute-stage multiply unit and its neighbours:
//   - type-code constants for the multiply family ({long, U, A})
//   - the multiply unit state encoding
//   - CPSR flag bit positions, so writeback can merge flag_n / flag_z
//   - a legality helper for the type code
// -----------------------------------------------------------------------------
package limb_pkg;

  // Multiply type codes, laid out as {long, U, A}
  localparam logic [2:0] MUL_T   = 3'b000;
  localparam logic [2:0] MLA_T   = 3'b001;
  localparam logic [2:0] UMULL_T = 3'b100;
  localparam logic [2:0] UMLAL_T = 3'b101;
  localparam logic [2:0] SMULL_T = 3'b110;
  localparam logic [2:0] SMLAL_T = 3'b111;

  // CPSR flag bit positions
  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

  // Multiply unit sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // 010 and 011 have no multiply meaning; every other code is legal
  function automatic logic type_is_legal(input logic [2:0] code);
    logic ok;
    case (code)
      MUL_T, MLA_T, UMULL_T, UMLAL_T, SMULL_T, SMLAL_T: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multiply_unit_if.sv
// -----------------------------------------------------------------------------
// multiply_unit_if
// Start and result handshakes of the multiply unit.
//   master : issuing side (execute-stage control / testbench)
//   slave  : the multiply unit
// Signals:
//   start_valid/start_ready : operand handshake
//   a, b, c, d              : multiplicand, multiplier, accumulate high/short,
//                             accumulate low word (long forms)
//   op_type                 : {long, U, A}; called "type" in the ISA, renamed
//                             because type is a SystemVerilog keyword
//   result_valid/result_ready : result handshake
//   result, flag_n, flag_z, error : result payload
// -----------------------------------------------------------------------------
interface multiply_unit_if #(
  parameter int WIDTH = 32
) ();

  logic               start_valid;
  logic               start_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [WIDTH-1:0]   d;
  logic [2:0]         op_type;
  logic               result_valid;
  logic               result_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag_n;
  logic               flag_z;
  logic               error;

  modport master (
    output start_valid, a, b, c, d, op_type, result_ready,
    input  start_ready, result_valid, result, flag_n, flag_z, error
  );

  modport slave (
    input  start_valid, a, b, c, d, op_type, result_ready,
    output start_ready, result_valid, result, flag_n, flag_z, error
  );

endinterface

// File: rtl/multiply_unit_mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
// Combinational radix-2^BITS_PER_CYCLE partial-product adder.
//   partial      in  2*WIDTH  running partial product
//   multiplicand in  WIDTH    unsigned multiplicand magnitude
//   shift        in  SHIFT_W  weight of the current digit (step * BITS_PER_CYCLE)
//   digit        in  BPC      current multiplier digit
//   next_partial out 2*WIDTH  partial + (multiplicand * digit) << shift
// -----------------------------------------------------------------------------
module mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int SHIFT_W        = 6
) (
  input  logic [2*WIDTH-1:0]        partial,
  input  logic [WIDTH-1:0]          multiplicand,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  output logic [2*WIDTH-1:0]        next_partial
);

  logic [2*WIDTH-1:0] mcand_ext_s;
  logic [2*WIDTH-1:0] term_s;

  // Digit times multiplicand as a sum of shifted copies, then placed at the digit weight
  always_comb begin
    mcand_ext_s = {{WIDTH{1'b0}}, multiplicand};
    term_s      = {(2*WIDTH){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) begin
        term_s = term_s + (mcand_ext_s << i);
      end else begin
        term_s = term_s;
      end
    end
    next_partial = partial + (term_s << shift);
  end

endmodule

// File: rtl/multiply_unit.sv
// -----------------------------------------------------------------------------
// multiply_unit
// Iterative multiply / multiply-accumulate for the execute stage. Consumes
// BITS_PER_CYCLE multiplier bits per CALC cycle, optionally stops as soon as
// the remaining multiplier is zero, then applies sign correction and the
// accumulate term in ACC and presents the result in DONE until taken.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave side of multiply_unit_if (start/result handshakes, operands,
//          op_type, result, flag_n, flag_z, error)
// -----------------------------------------------------------------------------
module multiply_unit
  import limb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int EARLY_TERM     = 1
) (
  input  logic           clk,
  input  logic           reset,
  multiply_unit_if.slave bus
);

  localparam int STEPS    = WIDTH / BITS_PER_CYCLE;
  localparam int STEP_W   = $clog2(STEPS + 1);
  localparam int SHIFT_W  = $clog2(2 * WIDTH);
  localparam int BPC_LOG2 = $clog2(BITS_PER_CYCLE);

  mul_state_e         state_r;
  mul_state_e         state_next_s;

  // Operand and iteration registers
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] accum_r;
  logic [2*WIDTH-1:0] partial_r;
  logic [STEP_W-1:0]  step_r;
  logic               neg_r;
  logic               long_r;

  // Result registers
  logic [2*WIDTH-1:0] result_r;
  logic               flag_n_r;
  logic               flag_z_r;
  logic               error_r;

  // Accept-cycle operand conditioning
  logic               legal_s;
  logic               signed_op_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] accum_in_s;

  // Iteration datapath
  logic [WIDTH-1:0]   mplier_shift_s;
  logic [STEP_W-1:0]  step_inc_s;
  logic [SHIFT_W-1:0] shift_s;
  logic               last_step_s;
  logic               calc_done_s;
  logic [2*WIDTH-1:0] partial_next_s;

  // Final accumulate datapath
  logic [2*WIDTH-1:0] product_s;
  logic [2*WIDTH-1:0] sum_s;
  logic [2*WIDTH-1:0] acc_result_s;
  logic               acc_n_s;
  logic               acc_z_s;

  // Handshake outputs
  logic               start_ready_s;
  logic               result_valid_s;

  // Two's-complement magnitude; the most negative value maps onto 2^(WIDTH-1),
  // which still fits the unsigned WIDTH-bit range used by the shift-add loop.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Operand decode used on the accept edge: legality, signedness, magnitudes, addend
  always_comb begin
    legal_s     = type_is_legal(bus.op_type);
    signed_op_s = (bus.op_type == SMULL_T) || (bus.op_type == SMLAL_T);
    a_mag_s     = magnitude(bus.a, signed_op_s);
    b_mag_s     = magnitude(bus.b, signed_op_s);
    if (!bus.op_type[0]) begin
      accum_in_s = {(2*WIDTH){1'b0}};
    end else if (bus.op_type[2]) begin
      accum_in_s = {bus.c, bus.d};
    end else begin
      accum_in_s = {{WIDTH{1'b0}}, bus.c};
    end
  end

  // Iteration control: digit weight, step count and CALC exit condition
  always_comb begin
    mplier_shift_s = mplier_r >> BITS_PER_CYCLE;
    step_inc_s     = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
    shift_s        = SHIFT_W'(step_r) << BPC_LOG2;
    last_step_s    = (step_inc_s == STEP_W'(STEPS));
    calc_done_s    = last_step_s ||
                     ((EARLY_TERM != 0) && (mplier_shift_s == {WIDTH{1'b0}}));
  end

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHIFT_W        (SHIFT_W)
  ) u_mul_step (
    .partial      (partial_r),
    .multiplicand (mcand_r),
    .shift        (shift_s),
    .digit        (mplier_r[BITS_PER_CYCLE-1:0]),
    .next_partial (partial_next_s)
  );

  // Sign correction, accumulate and flag generation for the ACC cycle
  always_comb begin
    if (neg_r) begin
      product_s = ~partial_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      product_s = partial_r;
    end
    sum_s = product_s + accum_r;
    if (long_r) begin
      acc_result_s = sum_s;
      acc_n_s      = sum_s[2*WIDTH-1];
      acc_z_s      = (sum_s == {(2*WIDTH){1'b0}});
    end else begin
      // Short forms keep only the low word; the upper half reads as zero
      acc_result_s = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
      acc_n_s      = sum_s[WIDTH-1];
      acc_z_s      = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.start_valid) begin
          state_next_s = ST_IDLE;
        end else if (!legal_s) begin
          state_next_s = ST_DONE;
        end else if ((EARLY_TERM != 0) && (b_mag_s == {WIDTH{1'b0}})) begin
          state_next_s = ST_ACC;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_CALC: begin
        if (calc_done_s) begin
          state_next_s = ST_ACC;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_ACC: begin
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    start_ready_s  = 1'b0;
    result_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_ready_s  = 1'b1;
        result_valid_s = 1'b0;
      end
      ST_DONE: begin
        start_ready_s  = 1'b0;
        result_valid_s = 1'b1;
      end
      default: begin
        start_ready_s  = 1'b0;
        result_valid_s = 1'b0;
      end
    endcase
  end

  // Operand capture, shift-add iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      accum_r   <= {(2*WIDTH){1'b0}};
      partial_r <= {(2*WIDTH){1'b0}};
      step_r    <= {STEP_W{1'b0}};
      neg_r     <= 1'b0;
      long_r    <= 1'b0;
      result_r  <= {(2*WIDTH){1'b0}};
      flag_n_r  <= 1'b0;
      flag_z_r  <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start_valid) begin
            mcand_r   <= a_mag_s;
            mplier_r  <= b_mag_s;
            accum_r   <= accum_in_s;
            partial_r <= {(2*WIDTH){1'b0}};
            step_r    <= {STEP_W{1'b0}};
            neg_r     <= signed_op_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            long_r    <= bus.op_type[2];
            // Illegal codes skip the datapath and report straight from DONE
            if (!legal_s) begin
              result_r <= {(2*WIDTH){1'b0}};
              flag_n_r <= 1'b0;
              flag_z_r <= 1'b0;
              error_r  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          partial_r <= partial_next_s;
          mplier_r  <= mplier_shift_s;
          step_r    <= step_inc_s;
        end
        ST_ACC: begin
          result_r <= acc_result_s;
          flag_n_r <= acc_n_s;
          flag_z_r <= acc_z_s;
          error_r  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_s;
  assign bus.result_valid = result_valid_s;
  assign bus.result       = result_r;
  assign bus.flag_n       = flag_n_r;
  assign bus.flag_z       = flag_z_r;
  assign bus.error        = error_r;

endmodule

// File: tb/tb_multiply_unit.sv
// -----------------------------------------------------------------------------
// tb_multiply_unit
// Directed vectors for multiply_unit at the default parameters. An arithmetic
// model gives the expected result, flags, error and start-to-valid latency for
// each accepted operation; a monitor compares the DUT against it on every
// cycle. Each vector also carries hand-computed literals that pin the model.
// -----------------------------------------------------------------------------
module tb_multiply_unit;
  import limb_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  multiply_unit_if #(.WIDTH(W)) bus_if ();

  multiply_unit #(
    .WIDTH          (W),
    .BITS_PER_CYCLE (2),
    .EARLY_TERM     (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        err;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic int bitlen(input logic [63:0] v);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  // Expected outcome from plain arithmetic on the operands
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 input logic [2:0] t);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] mag;
    logic [31:0] lo;
    longint      sa;
    longint      sb;
    e.res = 64'h0;
    e.n   = 1'b0;
    e.z   = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    if (t == 3'b010 || t == 3'b011) begin
      e.err = 1'b1;
      return e;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (t[2] && t[1]) begin
      p   = sa * sb;
      mag = (sb < 0) ? -sb : sb;
    end else begin
      p   = {32'h0, a} * {32'h0, b};
      mag = {32'h0, b};
    end
    if (t[2]) begin
      e.res = p + (t[0] ? {c, d} : 64'h0);
      e.n   = e.res[63];
      e.z   = (e.res == 64'h0);
    end else begin
      lo    = p[31:0] + (t[0] ? c : 32'h0);
      e.res = {32'h0, lo};
      e.n   = lo[31];
      e.z   = (lo == 32'h0);
    end
    // two multiplier bits per cycle; a zero multiplier skips straight to ACC
    e.lat = (mag == 64'h0) ? 2 : (bitlen(mag) + 1) / 2 + 2;
    return e;
  endfunction

  // Monitor: every cycle, compare DUT outputs with the in-flight expectation
  exp_t cur;
  bit   busy     = 1'b0;
  bit   rst_seen = 1'b0;
  int   j        = 0;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_valid", bus_if.result_valid, 1'b0);
      chk("rst_start_ready", bus_if.start_ready, 1'b1);
      chk("rst_result", bus_if.result, 64'h0);
      chk("rst_flags_err", {bus_if.flag_n, bus_if.flag_z, bus_if.error}, 3'b000);
    end else if (busy) begin
      j++;
      chk("busy_start_ready", bus_if.start_ready, 1'b0);
      if (j >= cur.lat - 1) begin
        chk("mon_valid", bus_if.result_valid, 1'b1);
        chk("mon_result", bus_if.result, cur.res);
        chk("mon_flags_err", {bus_if.flag_n, bus_if.flag_z, bus_if.error},
            {cur.n, cur.z, cur.err});
        if (bus_if.result_valid === 1'b1 && bus_if.result_ready === 1'b1) busy = 1'b0;
      end else begin
        chk("mon_early_valid", bus_if.result_valid, 1'b0);
      end
    end else begin
      chk("idle_valid", bus_if.result_valid, 1'b0);
      chk("idle_start_ready", bus_if.start_ready, 1'b1);
    end
    rst_seen = reset;
    if (reset) begin
      busy = 1'b0;
    end else if (!busy && bus_if.start_valid === 1'b1 && bus_if.start_ready === 1'b1) begin
      cur  = model(bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.op_type);
      busy = 1'b1;
      j    = -1;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input logic [2:0] t);
    bus_if.a           = a;
    bus_if.b           = b;
    bus_if.c           = c;
    bus_if.d           = d;
    bus_if.op_type     = t;
    bus_if.start_valid = 1'b1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus_if.result_valid !== 1'b1 && k < 40);
    ok = (bus_if.result_valid === 1'b1);
    if (!ok) timeout(name);
  endtask

  // One operation: pin the model with literals, run it, check the DUT literally
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d, input logic [2:0] t,
                        input logic [63:0] lit_res, input logic [2:0] lit_nze,
                        input int lit_lat);
    exp_t m;
    bit   ok;
    int   k;
    m = model(a, b, c, d, t);
    chk({name, "_model_res"}, m.res, lit_res);
    chk({name, "_model_nze"}, {m.n, m.z, m.err}, lit_nze);
    chk({name, "_model_lat"}, 64'(m.lat), 64'(lit_lat));
    @(posedge clk); #1;
    issue(a, b, c, d, t);
    @(negedge clk);
    k = 0;
    while (bus_if.start_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus_if.start_ready !== 1'b1) timeout({name, "_accept"});
    @(posedge clk); #1;
    bus_if.start_valid = 1'b0;
    wait_valid({name, "_valid"}, ok);
    if (ok) begin
      chk({name, "_res"}, bus_if.result, lit_res);
      chk({name, "_nze"}, {bus_if.flag_n, bus_if.flag_z, bus_if.error}, lit_nze);
    end
    @(posedge clk); #1;
    bus_if.result_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.result_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset               = 1'b1;
    bus_if.start_valid  = 1'b0;
    bus_if.a            = 32'h0;
    bus_if.b            = 32'h0;
    bus_if.c            = 32'h0;
    bus_if.d            = 32'h0;
    bus_if.op_type      = 3'b000;
    bus_if.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    //      name          a             b             c             d             type     result                  {n,z,e} lat
    run_op("mul7x6",      32'd7,        32'd6,        32'd0,        32'd0,        MUL_T,   64'h000000000000002A,   3'b000, 4);
    run_op("umull_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        UMULL_T, 64'hFFFFFFFE00000001,   3'b100, 18);
    run_op("smull_min",   32'h80000000, 32'h80000000, 32'd0,        32'd0,        SMULL_T, 64'h4000000000000000,   3'b000, 18);
    run_op("smlal_neg",   32'hFFFFFFFE, 32'd3,        32'd0,        32'd10,       SMLAL_T, 64'h0000000000000004,   3'b000, 3);
    run_op("mul_wrap",    32'h00010000, 32'h00010000, 32'd0,        32'd0,        MUL_T,   64'h0000000000000000,   3'b010, 11);
    run_op("mla_bzero",   32'd9,        32'd0,        32'd5,        32'd0,        MLA_T,   64'h0000000000000005,   3'b000, 2);
    run_op("illegal010",  32'd1,        32'd2,        32'd3,        32'd4,        3'b010,  64'h0000000000000000,   3'b001, 1);
    run_op("illegal011",  32'd5,        32'd6,        32'd7,        32'd8,        3'b011,  64'h0000000000000000,   3'b001, 1);
    run_op("umlal_wrap",  32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, UMLAL_T, 64'h00000000FFFFFFFF,   3'b000, 11);
    run_op("smull_neg",   32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,        32'd0,        SMULL_T, 64'hFFFFFFFF80000001,   3'b100, 18);
    run_op("smlal_zero",  32'd5,        32'hFFFFFFFF, 32'd0,        32'd5,        SMLAL_T, 64'h0000000000000000,   3'b010, 3);
    run_op("mla_wrap",    32'd2,        32'd3,        32'hFFFFFFFA, 32'd0,        MLA_T,   64'h0000000000000000,   3'b010, 3);
    run_op("mul_neg",     32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,        MUL_T,   64'h00000000FFFFFFFE,   3'b100, 3);

    // Stalled result with start_valid held high: second operation waits for IDLE
    @(posedge clk); #1;
    issue(32'd7, 32'd6, 32'd0, 32'd0, MUL_T);
    @(posedge clk); #1;
    issue(32'd5, 32'd5, 32'd0, 32'd0, MUL_T);
    wait_valid("stall_first_valid", ok);
    if (ok) chk("stall_first_res", bus_if.result, 64'h2A);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_held_res", bus_if.result, 64'h2A);
    chk("stall_start_ready", bus_if.start_ready, 1'b0);
    @(posedge clk); #1;
    bus_if.result_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.result_ready = 1'b0;
    @(negedge clk);
    chk("stall_reopen_ready", bus_if.start_ready, 1'b1);
    @(posedge clk); #1;
    bus_if.start_valid = 1'b0;
    wait_valid("stall_second_valid", ok);
    if (ok) chk("stall_second_res", bus_if.result, 64'd25);
    @(posedge clk); #1;
    bus_if.result_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.result_ready = 1'b0;

    // Reset in the middle of CALC discards the operation
    @(posedge clk); #1;
    issue(32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, UMULL_T);
    @(posedge clk); #1;
    bus_if.start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midcalc_rst_valid", bus_if.result_valid, 1'b0);
    chk("midcalc_rst_ready", bus_if.start_ready, 1'b1);
    run_op("mul3x4",      32'd3,        32'd4,        32'd0,        32'd0,        MUL_T,   64'h000000000000000C,   3'b000, 4);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
